// File: rtl/stream_fifo.sv
// Stream FIFO with valid/ready handshakes, TLAST sideband and first-word-fall-through output.
// Block-RAM storage feeds a one-word head register; count covers both, capacity is 2**ADDR_WIDTH words.
module stream_fifo #(
    parameter int DATA_WIDTH    = 24,
    parameter int ADDR_WIDTH    = 5,
    parameter int AFULL_THRESH  = 28,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]       DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]       AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0]       AEMPTY_C = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);

    // Each entry is {last, data}.
    (* ram_style = "block" *) logic [DATA_WIDTH:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so a completely full RAM is distinguishable from empty.
    logic [ADDR_WIDTH:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH:0] wr_cmt_reg, wr_cmt_next;
    logic [ADDR_WIDTH:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]       count_reg, count_next;
    logic                out_valid_reg, out_valid_next;
    logic [DATA_WIDTH:0] out_word_reg;
    logic                afull_reg, afull_next;
    logic                aempty_reg, aempty_next;

    logic push;
    logic pop;
    logic ram_avail;
    logic load;

    assign s_ready = (count_reg != DEPTH_C);
    assign push    = s_valid & s_ready;
    assign pop     = out_valid_reg & m_ready;

    // Only words whose write has been committed for a full cycle are eligible for reading,
    // so the read port never targets the address being written on the same edge.
    assign ram_avail = (rd_ptr_reg != wr_cmt_reg);
    assign load      = ram_avail & (~out_valid_reg | pop);

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        wr_cmt_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        out_valid_next = out_valid_reg;
        afull_next     = afull_reg;
        aempty_next    = aempty_reg;

        if (flush) begin
            wr_ptr_next    = '0;
            wr_cmt_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            out_valid_next = 1'b0;
            afull_next     = 1'b0;
            aempty_next    = 1'b1;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (load) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            out_valid_next = load | (out_valid_reg & ~pop);

            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase

            afull_next  = (count_next >= AFULL_C);
            aempty_next = (count_next <= AEMPTY_C);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            wr_cmt_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            afull_reg     <= 1'b0;
            aempty_reg    <= 1'b1;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            wr_cmt_reg    <= wr_cmt_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            out_valid_reg <= out_valid_next;
            afull_reg     <= afull_next;
            aempty_reg    <= aempty_next;
        end
    end

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= {s_last, s_data};
        end
    end

    // Head register; keeps its last value whenever nothing new is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_word_reg <= '0;
        end else if (load && !flush) begin
            out_word_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
        end
    end

    assign m_data       = out_word_reg[DATA_WIDTH-1:0];
    assign m_last       = out_word_reg[DATA_WIDTH];
    assign m_valid      = out_valid_reg;
    assign count        = count_reg;
    assign almost_full  = afull_reg;
    assign almost_empty = aempty_reg;

endmodule

// File: tb/tb_stream_fifo.sv
// Randomised self-checking bench for stream_fifo against a queue-based reference model.
// The model keeps each word's acceptance edge and exposes it at the head two edges later.
module tb_stream_fifo;

    localparam int DW    = 24;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int AFT   = 28;
    localparam int AET   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic [AW:0]   count;
    logic          almost_full;
    logic          almost_empty;

    stream_fifo #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (AFT),
        .AEMPTY_THRESH(AET)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .count       (count),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW:0] w;
        int          acc;
    } ent_t;

    ent_t q[$];
    logic mdl_valid = 1'b0;
    int   cyc       = 0;
    int   vec_count = 0;
    int   err_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = q.size();
        check("count", 32'(count), 32'(sz));
        check("s_ready", 32'(s_ready), 32'(sz != DEPTH));
        check("almost_full", 32'(almost_full), 32'(sz >= AFT));
        check("almost_empty", 32'(almost_empty), 32'(sz <= AET));
        check("m_valid", 32'(m_valid), 32'(mdl_valid));
        if (mdl_valid) begin
            check("m_data", 32'(m_data), 32'(q[0].w[DW-1:0]));
            check("m_last", 32'(m_last), 32'(q[0].w[DW]));
        end
    endtask

    // Applies one cycle of inputs, advances the model on the edge, then compares.
    task automatic step(input logic sv, input logic [DW-1:0] d, input logic l,
                        input logic mr, input logic fl);
        logic do_push;
        logic do_pop;
        ent_t e;
        s_valid = sv;
        s_data  = d;
        s_last  = l;
        m_ready = mr;
        flush   = fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
            mdl_valid = 1'b0;
        end else begin
            do_push = sv && (q.size() != DEPTH);
            do_pop  = mdl_valid && mr;
            if (do_pop) begin
                void'(q.pop_front());
                mdl_valid = 1'b0;
            end
            if (do_push) begin
                e.w   = {l, d};
                e.acc = cyc;
                q.push_back(e);
            end
            if (!mdl_valid && q.size() > 0 && q[0].acc <= cyc - 2) begin
                mdl_valid = 1'b1;
            end
        end
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            step(1'b0, '0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        check("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        int pushed;
        int guard;
        logic sv;
        logic mr;
        logic [DW-1:0] d;

        rst     = 1'b1;
        flush   = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;

        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word: visible two edges after acceptance.
        step(1'b1, 24'hABCDEF, 1'b1, 1'b0, 1'b0);
        check("single_cnt", 32'(count), 32'd1);
        check("single_v0", 32'(m_valid), 32'd0);
        idle(1);
        check("single_v1", 32'(m_valid), 32'd0);
        idle(1);
        check("single_v2", 32'(m_valid), 32'd1);
        check("single_data", 32'(m_data), 32'hABCDEF);
        check("single_last", 32'(m_last), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("single_pop_cnt", 32'(count), 32'd0);
        check("single_pop_v", 32'(m_valid), 32'd0);

        // Fill to full with the consumer stalled.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DW'(i), (i % 5) == 4, 1'b0, 1'b0);
            check("fill_afull", 32'(almost_full), 32'((i + 1) >= AFT));
        end
        check("full_cnt", 32'(count), 32'd32);
        check("full_ready", 32'(s_ready), 32'd0);
        step(1'b1, 24'h777777, 1'b0, 1'b0, 1'b0);
        check("overfill_cnt", 32'(count), 32'd32);

        // Pop at full while pushing: the push is refused.
        step(1'b1, 24'h888888, 1'b0, 1'b1, 1'b0);
        check("fullpop_cnt", 32'(count), 32'd31);
        check("fullpop_ready", 32'(s_ready), 32'd1);
        drain();

        // Asynchronous reset mid-stream at count 7.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, DW'(24'h100 + i), 1'b0, 1'b0, 1'b0);
        end
        idle(2);
        check("pre_rst_cnt", 32'(count), 32'd7);
        rst = 1'b1;
        #2;
        check("arst_count", 32'(count), 32'd0);
        check("arst_m_valid", 32'(m_valid), 32'd0);
        check("arst_s_ready", 32'(s_ready), 32'd1);
        check("arst_aempty", 32'(almost_empty), 32'd1);
        q.delete();
        mdl_valid = 1'b0;
        @(posedge clk);
        #1;
        check("arst_hold_cnt", 32'(count), 32'd0);
        rst = 1'b0;

        // Flush colliding with push and pop.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'(24'h200 + i), 1'b0, 1'b0, 1'b0);
        end
        idle(3);
        check("pre_flush_cnt", 32'(count), 32'd10);
        step(1'b1, 24'h123456, 1'b1, 1'b1, 1'b1);
        check("flush_cnt", 32'(count), 32'd0);
        check("flush_valid", 32'(m_valid), 32'd0);
        check("flush_aempty", 32'(almost_empty), 32'd1);
        step(1'b1, 24'h000055, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("post_flush_v", 32'(m_valid), 32'd1);
        check("post_flush_data", 32'(m_data), 32'h000055);
        drain();

        // Random traffic across several pointer wraps.
        pushed = 0;
        guard  = 0;
        while (pushed < 200 && guard < 4000) begin
            sv = 1'($urandom_range(0, 99) < 60);
            mr = 1'($urandom_range(0, 99) < 45);
            d  = DW'($urandom);
            if (sv && q.size() != DEPTH) begin
                pushed++;
            end
            step(sv, d, 1'($urandom_range(0, 3) == 0), mr, 1'b0);
            guard++;
        end
        check("random_pushed", 32'(pushed), 32'd200);
        drain();

        // Full-rate streaming from empty settles at a constant occupancy of three.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, DW'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            if (k >= 2) begin
                check("stream_cnt", 32'(count), 32'd3);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
Parametrised synchronous stream FIFO for the DMA accelerator datapath. It replaces bare addressed RAM buffers between the AXI DMA stream interface and processing stages. Valid/ready handshakes on both sides, a TLAST sideband bit, first-word-fall-through output, occupancy count, almost-full/almost-empty flags and a synchronous flush. Block-RAM storage with a registered output stage.

Parameters:
DATA_WIDTH, 24, payload width in bits (TLAST carried separately).
ADDR_WIDTH, 5, log2 of capacity; DEPTH = 2**ADDR_WIDTH words total.
AFULL_THRESH, 28, almost_full asserted when count >= this value; legal range 1..DEPTH.
AEMPTY_THRESH, 4, almost_empty asserted when count <= this value; legal range 0..DEPTH-1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous clear of all contents
s_data  input  DATA_WIDTH  write payload
s_last  input  1  write TLAST
s_valid  input  1  write request
s_ready  output  1  FIFO can accept a word
m_data  output  DATA_WIDTH  head-of-FIFO payload
m_last  output  1  head-of-FIFO TLAST
m_valid  output  1  head word present
m_ready  input  1  consumer accepts head word
count  output  ADDR_WIDTH+1  words held, 0..DEPTH
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH

Behaviour:
- Reset (rst=1, async): pointers=0, count=0, m_valid=0, m_data=0, m_last=0, s_ready=1, almost_full=0, almost_empty=1. Outputs are stable while rst is held. Deassertion is synchronous to clk by the integrator.
- Push: s_valid & s_ready on a rising edge writes {s_last,s_data} into RAM at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: m_valid & m_ready on a rising edge consumes the head word.
- Storage: RAM (ram_style block) plus a 1-word output register holding the head. count covers both. Capacity is exactly DEPTH words.
- Read is FWFT. When the output register is empty or being popped and the RAM holds data, the next word is loaded into the output register.
- Write-to-output latency:
  - Word accepted on edge N into an empty FIFO appears with m_valid=1 after edge N+2.
  - One cycle goes to the RAM write, one to the synchronous read into the output register.
  - No RAM read-during-write bypass is required.
- Back-to-back pops with RAM non-empty sustain one word per cycle: m_valid stays high and m_data advances every edge.
- count:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Registered.
  - Never exceeds DEPTH, never underflows.
- count may reach 1 or 2 while m_valid is still 0 during the 2-cycle fill latency. count reflects accepted words, not presented words.
- s_ready = (count != DEPTH), derived from the count register only. There is no combinational path from m_ready to s_ready. When full, a pop on edge N raises s_ready after edge N.
- Simultaneous push and pop at full cannot occur (s_ready=0). At empty, a pop cannot occur (m_valid=0). A simultaneous push and pop at any other level keeps count constant.
- almost_full and almost_empty are registered, computed from the next count, so they change on the same edge as count.
- flush=1 at an edge:
  - Pointers and count go to 0, m_valid to 0.
  - Any push or pop in the same cycle is discarded.
  - Flags return to reset values.
  - flush has priority over all other operations.
- Pointer wrap-around at DEPTH-1 to 0 is seamless. Ordering is strictly preserved across the wrap.
- s_data and s_last are don't-care when s_valid=0.
- While m_valid=0, m_data holds its last value.

Test Plan:
- Reset then idle: rst pulse mid-stream with count=7 -> count=0, m_valid=0, s_ready=1, almost_empty=1 immediately, without waiting for an edge.
- Single word: push 0xABCDEF with s_last=1 on edge 0 -> count=1 after edge 0; m_valid=1, m_data=0xABCDEF, m_last=1 after edge 2; pop -> count=0, m_valid=0.
- Fill to full (ADDR_WIDTH=5): push 32 words 0..31 with m_ready=0 -> s_ready=0 and count=32 after the 32nd push; almost_full rises exactly when count=28; a 33rd s_valid is not accepted.
- Wrap and ordering: continuous push/pop with random s_valid/m_ready for 200 words -> output sequence equals input sequence including TLAST; count never >32; full-rate streaming when both sides are always ready shows a constant count.
- Flush collision: count=10 with push and pop asserted together with flush -> after the edge count=0, m_valid=0; the next pushed word 0x000055 is the first word out.
- Full plus pop: count=32, assert m_ready one cycle -> count=31, s_ready=1 after that edge; push the same cycle is refused.
